// File: rtl/du_reg_dumper_if.sv
// Start request, register-file debug read port and UART TX byte handshake of the register dumper.
// The dumper takes the master side; the debug controller, register file and UART TX take the slave side.
interface du_reg_dumper_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              i_start;
    logic [ADDR_W-1:0] o_du_reg_addr;
    logic [DATA_W-1:0] i_du_reg_data;
    logic [7:0]        o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;
    logic              o_busy;
    logic              o_done;

    modport master (
        input  i_start,
        input  i_du_reg_data,
        input  i_tx_ready,
        output o_du_reg_addr,
        output o_tx_data,
        output o_tx_valid,
        output o_busy,
        output o_done
    );

    modport slave (
        output i_start,
        output i_du_reg_data,
        output i_tx_ready,
        input  o_du_reg_addr,
        input  o_tx_data,
        input  o_tx_valid,
        input  o_busy,
        input  o_done
    );
endinterface

// File: rtl/du_reg_dumper.sv
// Walks the register-file debug port and streams every register MSB-first as bytes to the UART TX.
// Define DU_DUMP_CHECKSUM_EN to append an XOR checksum byte of the whole dump after the last register.
module du_reg_dumper #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input logic             i_clk,
    input logic             i_reset,
    du_reg_dumper_if.master bus
);
    localparam int BYTES  = DATA_W / 8;
    localparam int BIDX_W = $clog2(BYTES + 1);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LATCH,
        SEND,
        NEXT,
        DONE
`ifdef DU_DUMP_CHECKSUM_EN
        ,
        CSUM
`endif
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   reg_idx;
    logic [BIDX_W-1:0]   byte_idx;
    logic [DATA_W-1:0]   shift;
    logic                tx_offer;
    logic                xfer;
    logic                last_byte;
    logic                last_reg;
`ifdef DU_DUMP_CHECKSUM_EN
    logic [7:0]          csum;
`endif

`ifdef DU_DUMP_CHECKSUM_EN
    assign tx_offer = (state == SEND) || (state == CSUM);
`else
    assign tx_offer = (state == SEND);
`endif
    assign xfer      = tx_offer && bus.i_tx_ready;
    assign last_byte = (byte_idx == BIDX_W'(BYTES - 1));
    assign last_reg  = (reg_idx == ADDR_W'(NUM_REGS - 1));

    // The address only moves on entry to READ, so it is stable through READ and LATCH.
    assign bus.o_du_reg_addr = reg_idx;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next     = state;
        bus.o_tx_valid = tx_offer;
        bus.o_tx_data  = shift[DATA_W-1 -: 8];
        bus.o_busy     = 1'b0;
        bus.o_done     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_next = READ;
                end
            end
            READ: begin
                bus.o_busy = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                bus.o_busy = 1'b1;
                state_next = SEND;
            end
            SEND: begin
                bus.o_busy = 1'b1;
                if (xfer && last_byte) begin
                    state_next = NEXT;
                end
            end
            NEXT: begin
                bus.o_busy = 1'b1;
                if (!last_reg) begin
                    state_next = READ;
                end else begin
`ifdef DU_DUMP_CHECKSUM_EN
                    state_next = CSUM;
`else
                    state_next = DONE;
`endif
                end
            end
`ifdef DU_DUMP_CHECKSUM_EN
            CSUM: begin
                bus.o_busy    = 1'b1;
                bus.o_tx_data = csum;
                if (xfer) begin
                    state_next = DONE;
                end
            end
`endif
            DONE: begin
                bus.o_done = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // The word is captured once in LATCH; later writes to the register file do not reach the stream.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reg_idx  <= '0;
            byte_idx <= '0;
            shift    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        reg_idx  <= '0;
                        byte_idx <= '0;
                    end
                end
                LATCH: begin
                    shift <= bus.i_du_reg_data;
                end
                SEND: begin
                    if (xfer) begin
                        shift    <= shift << 8;
                        byte_idx <= byte_idx + BIDX_W'(1);
                    end
                end
                NEXT: begin
                    byte_idx <= '0;
                    if (!last_reg) begin
                        reg_idx <= reg_idx + ADDR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

`ifdef DU_DUMP_CHECKSUM_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            csum <= '0;
        end else if (state == IDLE && bus.i_start) begin
            csum <= '0;
        end else if (state == SEND && xfer) begin
            csum <= csum ^ bus.o_tx_data;
        end
    end
`endif
endmodule

// File: tb/tb_du_reg_dumper.sv
// Self-checking bench for du_reg_dumper: vector table, hand-written corner sequences and randomized dumps
// compared against a byte-stream model built directly from the register contents.
module tb_du_reg_dumper;
    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int BYTES    = DATA_W / 8;
`ifdef DU_DUMP_CHECKSUM_EN
    localparam int CSUM_BYTES = 1;
`else
    localparam int CSUM_BYTES = 0;
`endif
    localparam int TOTAL_BYTES = NUM_REGS * BYTES + CSUM_BYTES;
    localparam int DUMP_CYCLES = 1 + NUM_REGS * (BYTES + 3) + CSUM_BYTES;

    typedef struct {
        logic [31:0]     word;
        int              stall;
        logic [0:3][7:0] exp_bytes;
    } vec_t;

    logic clk;
    logic reset;

    du_reg_dumper_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    du_reg_dumper #(
        .NUM_REGS(NUM_REGS),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    logic [DATA_W-1:0] regs      [NUM_REGS];
    logic [DATA_W-1:0] regs_snap [NUM_REGS];
    logic [7:0]        got[$];
    logic [7:0]        exp_q[$];
    logic [ADDR_W-1:0] addr_trace[$];

    int n_checks;
    int n_pass;
    int done_cnt;
    int stall_cycles;
    int hold_err;
    int addr_over;
    int ready_mode;
    int stall_len;
    int stall_cnt;

    assign bus.i_du_reg_data = regs[bus.o_du_reg_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Ready generator: 0 = always ready, 1 = stall_len cycles of back-pressure per offered byte, 2 = random.
    initial begin
        bus.i_tx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.i_tx_ready = 1'b1;
                1: begin
                    if (bus.o_tx_valid && stall_cnt < stall_len) begin
                        bus.i_tx_ready = 1'b0;
                        stall_cnt++;
                    end else if (bus.o_tx_valid) begin
                        bus.i_tx_ready = 1'b1;
                        stall_cnt = 0;
                    end else begin
                        bus.i_tx_ready = 1'b0;
                        stall_cnt = 0;
                    end
                end
                default: bus.i_tx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: collects accepted bytes and tallies protocol observations on the falling edge.
    initial begin
        logic       prev_valid;
        logic       prev_ready;
        logic       prev_reset;
        logic [7:0] prev_data;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        prev_reset = 1'b1;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset && bus.o_tx_valid && bus.i_tx_ready) got.push_back(bus.o_tx_data);
            if (bus.o_done) done_cnt++;
            if (bus.o_du_reg_addr > ADDR_W'(NUM_REGS - 1)) addr_over++;
            if (bus.o_tx_valid && !bus.i_tx_ready) stall_cycles++;
            if (!prev_reset && !reset && prev_valid && !prev_ready &&
                (!bus.o_tx_valid || bus.o_tx_data != prev_data)) hold_err++;
            prev_valid = bus.o_tx_valid;
            prev_ready = bus.i_tx_ready;
            prev_reset = reset;
            prev_data  = bus.o_tx_data;
        end
    end

    task automatic build_expected();
        logic [7:0] x;
        logic [7:0] b8;
        exp_q.delete();
        x = 8'h00;
        for (int n = 0; n < NUM_REGS; n++) begin
            for (int b = 0; b < BYTES; b++) begin
                b8 = 8'((regs_snap[n] >> (8 * (BYTES - 1 - b))) & 32'hFF);
                exp_q.push_back(b8);
                x = x ^ b8;
            end
        end
        if (CSUM_BYTES == 1) exp_q.push_back(x);
    endtask

    task automatic apply_stimulus(input int budget, input int restart_reg, input int write_reg,
                                  input bit start_in_done, output int first_valid_at, output int done_at);
        int cyc;
        bit restarted;
        bit clear_start;
        bit written;
        got.delete();
        addr_trace.delete();
        done_cnt     = 0;
        stall_cycles = 0;
        hold_err     = 0;
        for (int n = 0; n < NUM_REGS; n++) regs_snap[n] = regs[n];
        first_valid_at = -1;
        done_at        = -1;
        restarted      = 1'b0;
        clear_start    = 1'b0;
        written        = 1'b0;
        cyc            = 0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        while (cyc < budget && done_at < 0) begin
            @(negedge clk);
            cyc++;
            if (clear_start) begin
                bus.i_start = 1'b0;
                clear_start = 1'b0;
            end
            addr_trace.push_back(bus.o_du_reg_addr);
            if (bus.o_tx_valid && first_valid_at < 0) first_valid_at = cyc;
            if (bus.o_done) begin
                done_at = cyc;
                if (start_in_done) bus.i_start = 1'b1;
            end else begin
                if (restart_reg >= 0 && !restarted && bus.o_tx_valid &&
                    bus.o_du_reg_addr == ADDR_W'(restart_reg)) begin
                    bus.i_start = 1'b1;
                    restarted   = 1'b1;
                    clear_start = 1'b1;
                end
                if (write_reg >= 0 && !written && bus.o_tx_valid &&
                    bus.o_du_reg_addr == ADDR_W'(write_reg)) begin
                    regs[write_reg]       = ~regs[write_reg];
                    regs[write_reg+3]     = regs[write_reg+3] ^ 32'h5A5A_5A5A;
                    regs_snap[write_reg+3] = regs[write_reg+3];
                    written = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        check_output("done_within_budget", 32'(done_at > 0), 32'd1);
        if (done_at < 0) begin
            reset = 1'b1;
            @(posedge clk);
            #1;
            reset = 1'b0;
        end
    endtask

    task automatic compare_stream(input string tag);
        int bad;
        repeat (3) @(posedge clk);
        #1;
        build_expected();
        check_output({tag, "_byte_count"}, 32'(got.size()), 32'(exp_q.size()));
        bad = 0;
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            if (got[i] !== exp_q[i]) begin
                if (bad == 0) $display("[TB] %s first differing byte %0d: 0x%02h vs model 0x%02h",
                                       tag, i, got[i], exp_q[i]);
                bad++;
            end
        end
        check_output({tag, "_byte_errors"}, 32'(bad), 32'd0);
        check_output({tag, "_hold_errors"}, 32'(hold_err), 32'd0);
        check_output({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    endtask

    initial begin
        vec_t vecs[4];
        int   fv;
        int   da;
        int   errs;
        int   found;
        logic [7:0] last_exp;

        vecs[0] = '{32'hDEADBEEF, 5, {8'hDE, 8'hAD, 8'hBE, 8'hEF}};
        vecs[1] = '{32'h00000000, 0, {8'h00, 8'h00, 8'h00, 8'h00}};
        vecs[2] = '{32'hFFFFFFFF, 2, {8'hFF, 8'hFF, 8'hFF, 8'hFF}};
        vecs[3] = '{32'h80010203, 1, {8'h80, 8'h01, 8'h02, 8'h03}};

        n_checks   = 0;
        n_pass     = 0;
        done_cnt   = 0;
        addr_over  = 0;
        hold_err   = 0;
        ready_mode = 0;
        stall_len  = 0;
        stall_cnt  = 0;
        reset       = 1'b1;
        bus.i_start = 1'b0;
        for (int n = 0; n < NUM_REGS; n++) regs[n] = 32'h11223300 + 32'(n);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_output("rst_addr", 32'(bus.o_du_reg_addr), 32'd0);
        check_output("rst_tx_data", 32'(bus.o_tx_data), 32'd0);
        check_output("rst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check_output("rst_busy", 32'(bus.o_busy), 32'd0);
        check_output("rst_done", 32'(bus.o_done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        $display("[TB] full dump, incrementing pattern, ready held high");
        apply_stimulus(2000, -1, -1, 1'b0, fv, da);
        check_output("first_valid_latency", 32'(fv), 32'd3);
        check_output("done_latency", 32'(da), 32'(DUMP_CYCLES));
        errs = 0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (addr_trace.size() <= 7 * n + 1) errs++;
            else if (addr_trace[7*n] != ADDR_W'(n) || addr_trace[7*n+1] != ADDR_W'(n)) errs++;
        end
        check_output("addr_read_latch_hold", 32'(errs), 32'd0);
        check_output("incr_reg31_lsb", (got.size() >= 128) ? 32'(got[127]) : 32'hFFFF_FFFF, 32'h1F);
        compare_stream("incr");

        $display("[TB] vector table with back-pressure");
        for (int v = 0; v < 4; v++) begin
            for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom();
            regs[0]    = vecs[v].word;
            stall_cnt  = 0;
            stall_len  = vecs[v].stall;
            ready_mode = 1;
            apply_stimulus(6000, -1, -1, 1'b0, fv, da);
            for (int b = 0; b < 4; b++) begin
                check_output($sformatf("vec%0d_byte%0d", v, b),
                             (got.size() > b) ? 32'(got[b]) : 32'hFFFF_FFFF,
                             32'(vecs[v].exp_bytes[b]));
            end
            check_output($sformatf("vec%0d_stall_cycles", v), 32'(stall_cycles),
                         32'(vecs[v].stall * TOTAL_BYTES));
            compare_stream($sformatf("vec%0d", v));
        end

        $display("[TB] start re-pulsed while streaming register 7");
        ready_mode = 0;
        for (int n = 0; n < NUM_REGS; n++) regs[n] = 32'h11223300 + 32'(n);
        apply_stimulus(2000, 7, -1, 1'b0, fv, da);
        check_output("restart7_done_latency", 32'(da), 32'(DUMP_CYCLES));
        compare_stream("restart7");

        $display("[TB] start raised during the DONE cycle");
        apply_stimulus(2000, -1, -1, 1'b1, fv, da);
        errs = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.o_busy || bus.o_tx_valid) errs++;
        end
        check_output("start_in_done_ignored", 32'(errs), 32'd0);
        @(posedge clk);
        #1;
        compare_stream("after_done_start");

        $display("[TB] register writes during the dump, random ready");
        for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom();
        ready_mode = 2;
        apply_stimulus(4000, -1, 5, 1'b0, fv, da);
        compare_stream("late_write");

        $display("[TB] reset while sending register 12");
        ready_mode = 0;
        for (int n = 0; n < NUM_REGS; n++) regs[n] = 32'h11223300 + 32'(n);
        @(posedge clk);
        #1;
        done_cnt    = 0;
        bus.i_start = 1'b1;
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        found = 0;
        for (int c = 0; c < 500 && found == 0; c++) begin
            @(negedge clk);
            if (bus.o_tx_valid && bus.o_du_reg_addr == ADDR_W'(12)) found = 1;
        end
        check_output("reached_reg12_send", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_output("midrst_tx_valid", 32'(bus.o_tx_valid), 32'd0);
        check_output("midrst_busy", 32'(bus.o_busy), 32'd0);
        check_output("midrst_addr", 32'(bus.o_du_reg_addr), 32'd0);
        check_output("midrst_done", 32'(bus.o_done), 32'd0);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        check_output("midrst_no_done", 32'(done_cnt), 32'd0);
        check_output("midrst_stays_idle", 32'(bus.o_busy), 32'd0);
        @(posedge clk);
        #1;
        apply_stimulus(2000, -1, -1, 1'b0, fv, da);
        check_output("after_rst_first_addr", (addr_trace.size() > 0) ? 32'(addr_trace[0]) : 32'hFFFF_FFFF, 32'd0);
        compare_stream("after_reset");

        $display("[TB] single nonzero register, checksum corner");
        for (int n = 0; n < NUM_REGS; n++) regs[n] = 32'h0;
        regs[1] = 32'h000000FF;
        apply_stimulus(2000, -1, -1, 1'b0, fv, da);
        last_exp = (CSUM_BYTES == 1) ? 8'hFF : 8'h00;
        check_output("csum_case_count", 32'(got.size()), 32'(TOTAL_BYTES));
        check_output("csum_case_last", (got.size() > 0) ? 32'(got[got.size()-1]) : 32'hFFFF_FFFF,
                     32'(last_exp));
        compare_stream("csum_case");

        $display("[TB] randomized dumps");
        for (int it = 0; it < 4; it++) begin
            for (int n = 0; n < NUM_REGS; n++) regs[n] = $urandom();
            ready_mode = 2;
            apply_stimulus(4000, -1, -1, 1'b0, fv, da);
            compare_stream($sformatf("rand%0d", it));
        end

        check_output("addr_never_beyond_last", 32'(addr_over), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/du_reg_dumper.md
Name: du_reg_dumper

Overview:
- Debug-unit initiator for the register-file debug read port of the ID stage.
- On a start request it walks the register addresses 0..NUM_REGS-1 on the debug address bus.
- For each register it captures the 32-bit word and streams it as 4 bytes, MSB first, into the UART transmitter byte interface using a valid/ready handshake.
- It sits between the debug controller and the UART TX. It asserts busy so the controller can keep the pipeline halted during the dump.

Parameters:
- NUM_REGS, 32, number of registers dumped, starting at address 0.
- ADDR_W, 5, width of the debug register address bus.
- DATA_W, 32, register width. Must be a multiple of 8; BYTES = DATA_W/8.

Ports:
- i_clk  in  1  system clock; all logic is on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle dump request. Ignored while o_busy=1.
- o_du_reg_addr  out  ADDR_W  register address driven to the register-file debug port.
- i_du_reg_data  in  DATA_W  register data returned for o_du_reg_addr.
- o_tx_data  out  8  byte offered to the UART TX.
- o_tx_valid  out  1  o_tx_data is valid.
- i_tx_ready  in  1  UART TX accepts a byte. A transfer occurs on a cycle where o_tx_valid=1 and i_tx_ready=1.
- o_busy  out  1  high from the cycle after an accepted i_start until the cycle DONE is entered.
- o_done  out  1  one-cycle pulse when the last byte is accepted.

Behaviour:
- Reset values: o_du_reg_addr=0, o_tx_data=0, o_tx_valid=0, o_busy=0, o_done=0. State is IDLE and all counters are 0.
- FSM states: IDLE, READ, LATCH, SEND, NEXT, DONE.
- IDLE:
  - On i_start=1, set reg index=0 and byte index=0, then go to READ. o_busy rises on the next cycle.
- READ:
  - Drive o_du_reg_addr=reg index and hold it for one full cycle.
  - This covers both combinational and registered register-file read paths.
  - Go to LATCH.
- LATCH:
  - Capture i_du_reg_data into a DATA_W shift register.
  - Go to SEND.
- SEND:
  - o_tx_valid=1 and o_tx_data = shift register [DATA_W-1:DATA_W-8].
  - o_tx_data must stay stable while o_tx_valid=1 and i_tx_ready=0.
  - On transfer: shift left by 8 and increment byte index.
    - If byte index was BYTES-1, go to NEXT.
    - Otherwise stay in SEND. The next byte is valid in the next cycle, so back-to-back transfers are allowed.
- NEXT:
  - o_tx_valid=0.
  - If reg index = NUM_REGS-1, go to DONE.
  - Otherwise increment reg index, set byte index=0, and go to READ.
- DONE:
  - o_done=1 for exactly one cycle, o_busy=0, then go to IDLE.
- o_du_reg_addr holds its last value outside READ and is never driven beyond NUM_REGS-1.
- Latency:
  - Start to first o_tx_valid: 3 cycles.
  - With i_tx_ready held high, one register costs BYTES+3 cycles (READ, LATCH, BYTES×SEND, NEXT).
- Boundary conditions:
  - i_start while busy: ignored, with no restart or corruption.
  - i_start in the same cycle as the DONE state: ignored. Restart requires IDLE.
  - i_tx_ready held low indefinitely: the block stalls in SEND with data held. No timeout.
  - i_tx_ready high while o_tx_valid=0: no effect.
  - Changes on i_du_reg_data outside LATCH are ignored. A write to a register after its LATCH is not reflected in the dump.
  - i_reset mid-dump, in any state: the next cycle is IDLE with reset outputs. A pending byte is dropped, and no o_done is produced.
  - Counters are wide enough for NUM_REGS and BYTES with no wrap-around in normal operation.

Optional Feature:
- Macro DU_DUMP_CHECKSUM_EN.
- Defined:
  - Keep a running 8-bit XOR of every transferred byte, cleared on accepted i_start.
  - After the last register's NEXT, enter state CSUM. CSUM offers the XOR value with the same valid/ready rules, then goes to DONE.
  - Total bytes = NUM_REGS×BYTES+1. o_done follows acceptance of the checksum byte.
- Not defined:
  - No CSUM state and no XOR logic. Total bytes = NUM_REGS×BYTES.

Test Plan:
- Registers preloaded with r[n]=0x11223300+n, i_tx_ready=1, pulse i_start → byte stream 11 22 33 00, 11 22 33 01, …, 11 22 33 1F (128 bytes). Single o_done pulse; o_busy high throughout.
- r[0]=0xDEADBEEF, i_tx_ready low for 5 cycles at each byte → o_tx_data holds DE, AD, BE, EF during the stalls. No byte is lost or duplicated.
- i_start re-pulsed while streaming register 7 → stream continues unchanged. Total byte count stays 128.
- i_reset asserted while in SEND for register 12 → next cycle o_tx_valid=0, o_busy=0, o_du_reg_addr=0, no o_done. A new i_start restarts from register 0.
- Monitor o_du_reg_addr across a full dump → values 0..31 in order, each held through its READ and LATCH cycles; never exceeds 31.
- With DU_DUMP_CHECKSUM_EN, all registers=0 except r[1]=0x000000FF → 129 bytes, final byte 0xFF. Without the macro → 128 bytes.
